// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream controller.
// Read latency and buffer depth are tied together: the buffer must absorb every in-flight word.
package fifo_rd_stream_pkg;

    localparam int FIFO_RD_LATENCY    = 1;
    localparam int RD_BUF_DEPTH       = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef logic [1:0] slot_cnt_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream, as seen by the drain controller.
// master = controller side, slave = FIFO/consumer side.
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0]  rd_count;

    modport master (
        input  fifo_empty, fifo_data_out, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, rd_count
    );

    modport slave (
        output fifo_empty, fifo_data_out, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, rd_count
    );
endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// fifo_skid_buf: 2-entry ordered buffer; head is the oldest word, tail the second.
// Latency: a push is visible on head_o the next cycle. No backpressure: caller never pushes when full.
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output slot_cnt_t             count_o,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] head_o
);
    slot_cnt_t             count_q, count_d;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) head_d = data_i;
                else                 tail_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: the incoming word lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: ;
        endcase
        if (clear_i) count_d = 2'd0;
        vld_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            vld_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o = count_q;
    assign vld_o   = vld_q;
    assign head_o  = head_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port (1-cycle registered data) into a valid/ready stream with a delivered-word counter.
// Latency: pop issued in N, word on m_data in N+2. Backpressure: pops stop once buffered+in-flight words reach 2.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic            rd_clk,
    input  logic            rst,
    fifo_rd_stream_if.master bus
);
    slot_cnt_t             buf_count;
    logic                  buf_vld;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            occ;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

    assign pop = buf_vld && bus.m_ready;

    // Occupancy after this cycle's pop, counting the word already requested from the FIFO.
    assign occ = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

    assign rd_en = !rst && !bus.flush && !bus.fifo_empty && (occ < 3'(RD_BUF_DEPTH));

    always_comb begin
        inflight_d = rd_en;
        rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (rd_clk),
        .rst     (rst),
        .clear_i (bus.flush),
        .push_i  (inflight_q),
        .data_i  (bus.fifo_data_out),
        .pop_i   (pop),
        .count_o (buf_count),
        .vld_o   (buf_vld),
        .head_o  (buf_head)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = buf_vld;
    assign bus.m_data     = buf_head;
    assign bus.rd_count   = rd_count_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO with registered read data, directed traffic, flush, reset and counter wrap.
module tb_fifo_rd_stream;
    logic rd_clk;
    logic rst;

    fifo_rd_stream_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .rd_clk (rd_clk),
        .rst    (rst),
        .bus    (bus.master)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // FIFO model: ring of 1024 words, wr_total words written so far.
    logic [7:0] mem [0:1023];
    int         rd_ptr;
    int         wr_total;
    logic       fifo_clr;

    assign bus.fifo_empty = (rd_ptr >= wr_total);

    always @(posedge rd_clk) begin
        if (fifo_clr) begin
            rd_ptr <= 0;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_data_out <= mem[rd_ptr % 1024];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    logic [7:0] outq[$];
    int         rden_cnt;
    int         underflow;
    int         cnt_viol;

    always @(negedge rd_clk) begin
        if (!rst && bus.m_valid && bus.m_ready) outq.push_back(bus.m_data);
        if (bus.fifo_rd_en) begin
            rden_cnt++;
            if (bus.fifo_empty) underflow++;
        end
        if (dut.u_buf.count_o > 2'd2) cnt_viol++;
    end

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic fifo_reset();
        fifo_clr    = 1'b1;
        wr_total    = 0;
        bus.m_ready = 1'b0;
        tick();
        fifo_clr = 1'b0;
    endtask

    task automatic chk_seq(input string tag, input int base, input logic [7:0] exp[$]);
        int err;
        err = 0;
        chk({tag, "_n"}, 32'(outq.size() - base), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            if (base + k >= outq.size() || outq[base + k] !== exp[k]) err++;
        end
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int            base;
        int            r0;
        int            err;
        int            cyc;
        logic [7:0]    exp[$];

        total = 0;
        bad   = 0;
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        fifo_clr    = 1'b1;
        wr_total    = 4;
        repeat (3) tick();
        chk("rst_rden", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_vld", 32'(bus.m_valid), 32'd0);
        chk("rst_data", 32'(bus.m_data), 32'd0);
        chk("rst_cnt", 32'(bus.rd_count), 32'd0);
        wr_total = 0;
        rst      = 1'b0;
        fifo_clr = 1'b0;
        tick();

        // Full-throughput drain of 8 words.
        base = outq.size();
        r0   = rden_cnt;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        wr_total    = 8;
        bus.m_ready = 1'b1;
        #1;
        chk("t1_rden_first", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        tick();
        err = 0;
        for (int k = 0; k < 8; k++) begin
            if (!bus.m_valid || bus.m_data !== 8'(k + 1)) err++;
            tick();
        end
        chk("t1_b2b_err", 32'(err), 32'd0);
        repeat (4) tick();
        exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        chk_seq("t1_seq", base, exp);
        chk("t1_rdcnt", 32'(bus.rd_count), 32'd8);
        chk("t1_pops", 32'(rden_cnt - r0), 32'd8);
        chk("t1_underflow", 32'(underflow), 32'd0);

        // Backpressure: 4 words, consumer stalled for 10 cycles.
        fifo_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
        r0       = rden_cnt;
        wr_total = 4;
        err      = 0;
        repeat (10) begin
            tick();
            if (bus.m_valid && bus.m_data !== 8'h01) err++;
        end
        chk("t2_pops", 32'(rden_cnt - r0), 32'd2);
        chk("t2_vld", 32'(bus.m_valid), 32'd1);
        chk("t2_data", 32'(bus.m_data), 32'h01);
        chk("t2_hold_err", 32'(err), 32'd0);
        base = outq.size();
        bus.m_ready = 1'b1;
        repeat (10) tick();
        exp = {8'h01, 8'h02, 8'h03, 8'h04};
        chk_seq("t2_seq", base, exp);
        chk("t2_rdcnt", 32'(bus.rd_count), 32'd12);

        // Irregular arrival and random consumer stalls over 200 words.
        fifo_reset();
        for (int i = 0; i < 200; i++) mem[i] = 8'(i * 7 + 3);
        base = outq.size();
        cyc  = 0;
        while ((outq.size() - base) < 200 && cyc < 3000) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if (wr_total < 200 && $urandom_range(0, 2) != 0) wr_total = wr_total + 1;
            tick();
            cyc++;
        end
        exp.delete();
        for (int i = 0; i < 200; i++) exp.push_back(8'(i * 7 + 3));
        chk_seq("t3_seq", base, exp);
        chk("t3_rdcnt", 32'(bus.rd_count), 32'd212);
        chk("t3_cnt_le2", 32'(cnt_viol), 32'd0);
        chk("t3_underflow", 32'(underflow), 32'd0);

        // Flush with a full buffer while stalled.
        fifo_reset();
        for (int i = 0; i < 6; i++) mem[i] = 8'(8'h10 + i);
        wr_total = 6;
        repeat (5) tick();
        chk("t4a_vld", 32'(bus.m_valid), 32'd1);
        chk("t4a_data", 32'(bus.m_data), 32'h10);
        bus.flush = 1'b1;
        #1;
        chk("t4a_rden_flush", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("t4a_vld_after", 32'(bus.m_valid), 32'd0);
        base = outq.size();
        bus.m_ready = 1'b1;
        repeat (10) tick();
        exp = {8'h12, 8'h13, 8'h14, 8'h15};
        chk_seq("t4a_seq", base, exp);
        chk("t4a_rdcnt", 32'(bus.rd_count), 32'd216);

        // Flush mid-stream: pop completes, captured word dropped, next FIFO word follows.
        fifo_reset();
        for (int i = 0; i < 10; i++) mem[i] = 8'(8'h20 + i);
        base        = outq.size();
        wr_total    = 10;
        bus.m_ready = 1'b1;
        repeat (3) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4b_vld_after", 32'(bus.m_valid), 32'd0);
        repeat (15) tick();
        exp = {8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
        chk_seq("t4b_seq", base, exp);
        chk("t4b_rdcnt", 32'(bus.rd_count), 32'd225);

        // Reset mid-stream: words in the buffer and in flight are lost, FIFO keeps its place.
        fifo_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + i);
        base        = outq.size();
        wr_total    = 16;
        bus.m_ready = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("t5_rden_rst", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        rst = 1'b0;
        chk("t5_vld", 32'(bus.m_valid), 32'd0);
        chk("t5_data", 32'(bus.m_data), 32'd0);
        chk("t5_rdcnt0", 32'(bus.rd_count), 32'd0);
        repeat (20) tick();
        exp = {8'h30, 8'h31, 8'h32};
        for (int i = 5; i < 16; i++) exp.push_back(8'(8'h30 + i));
        chk_seq("t5_seq", base, exp);
        chk("t5_rdcnt", 32'(bus.rd_count), 32'd11);

        // Counter wrap: 65540 words.
        rst = 1'b1;
        fifo_reset();
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        base        = outq.size();
        wr_total    = 65540;
        bus.m_ready = 1'b1;
        repeat (65550) tick();
        chk("t6_n", 32'(outq.size() - base), 32'd65540);
        chk("t6_rdcnt_wrap", 32'(bus.rd_count), 32'd4);
        chk("t6_cnt_le2", 32'(cnt_viol), 32'd0);
        chk("t6_underflow", 32'(underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
